conv_out_buffer: RTL and testbench

Elastic output stage placed directly downstream of the per-channel convolution core. The conv core has no backpressure, so this block absorbs its valid/sop/eop pixel stream in a FIFO and re-emits it to a consumer (frame writer, DMA, video out) under a valid/ready handshake. It also checks frame integrity: sop/eop ordering and pixel count against the expected cropped frame size. It raises sticky error flags and a per-frame completion pulse.

---
 rtl/conv_stream_pkg.sv | 35 +++
 rtl/conv_out_buffer_sdp_ram.sv | 50 +++++
 rtl/conv_out_buffer.sv | 254 +++++++++++++++++++++++++
 tb/tb_conv_out_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// -----------------------------------------------------------------------------
// conv_stream_pkg
//
// Purpose: shared types and constants for the convolution output stream.
//   pix_beat_t         : one buffered beat {eop, sop, data}, MSB first. The
//                        output buffer stores beats in exactly this bit order.
//   ALMOST_FULL_MARGIN : almost_full asserts when free space drops to this many
//                        beats or fewer.
//   chk_state_t        : frame-integrity checker states.
// No ports (package).
// -----------------------------------------------------------------------------
package conv_stream_pkg;

    // Default pixel width of the conv core output.
    localparam int CONV_PIX_WIDTH = 8;

    // almost_full threshold is DEPTH - ALMOST_FULL_MARGIN.
    localparam int ALMOST_FULL_MARGIN = 4;

    // Bit layout of a stored beat. When conv_out_buffer is built with a
    // different PIX_WIDTH it packs the same {eop, sop, data} order into a
    // plain vector.
    typedef struct packed {
        logic                      eop;
        logic                      sop;
        logic [CONV_PIX_WIDTH-1:0] data;
    } pix_beat_t;

    // Frame checker: outside a frame, or between sop and eop.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } chk_state_t;

endpackage : conv_stream_pkg

// File: rtl/conv_out_buffer_sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
//
// Purpose: simple dual-port RAM, one write port and one read port on the same
//   clock. Read data is registered, so it appears one cycle after re_i. When
//   re_i is low the read register holds its value, which lets the buffer use it
//   directly as its output register. No reset on the array or the read
//   register so the tools can map it onto block RAM.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable (loads the read register)
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module sdp_ram #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The buffer never reads the address being written in the same cycle:
    // the read address always trails the write address by at least one
    // unread entry. Read-during-write behaviour is therefore irrelevant.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sdp_ram

// File: rtl/conv_out_buffer.sv
// -----------------------------------------------------------------------------
// conv_out_buffer
//
// Purpose: elastic output stage behind the convolution core. The core cannot
//   be stalled, so every beat it produces is captured in a FIFO (sdp_ram) and
//   re-emitted under a valid/ready handshake. A frame checker watches the
//   accepted input beats for sop/eop ordering and pixel count, raising sticky
//   error flags. frame_done pulses once per eop beat leaving the buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_data/i_valid      pixel and strobe from the conv core (no backpressure)
//   i_sop/i_eop         frame sideband travelling with the pixel
//   o_data/o_sop/o_eop  buffered beat
//   o_valid/o_ready     output handshake
//   exp_width/height    expected frame dimensions, sampled on each sop beat
//   clr_err             synchronous clear of the sticky error flags
//   fill_level          beats held (RAM plus output register), 0..DEPTH
//   almost_full         fill_level >= DEPTH - ALMOST_FULL_MARGIN
//   frame_done          one-cycle pulse after an eop beat is handed off
//   err_overflow        sticky: a beat arrived while the buffer was full
//   err_framing         sticky: sop/eop ordering violation
//   err_length          sticky: frame pixel count differed from expected
//   dbg_chk_state_o     current frame checker state (chk_state_t)
// -----------------------------------------------------------------------------
module conv_out_buffer
    import conv_stream_pkg::*;
#(
    parameter  int PIX_WIDTH = CONV_PIX_WIDTH,
    parameter  int DEPTH     = 1024,
    parameter  int DIM_WIDTH = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [PIX_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sop,
    input  logic                 i_eop,

    output logic [PIX_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 o_ready,

    input  logic [DIM_WIDTH-1:0] exp_width,
    input  logic [DIM_WIDTH-1:0] exp_height,
    input  logic                 clr_err,

    output logic [AW:0]          fill_level,
    output logic                 almost_full,
    output logic                 frame_done,
    output logic                 err_overflow,
    output logic                 err_framing,
    output logic                 err_length,

    output chk_state_t           dbg_chk_state_o
);

    localparam int BW = PIX_WIDTH + 2;          // {eop, sop, data}
    localparam int CW = 2 * DIM_WIDTH;          // pixel counter width

    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   AF_LEVEL = (AW+1)'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Handshake: the consumer takes a beat on every rising edge where
    // o_valid && o_ready. While o_valid is high and o_ready is low the
    // beat and o_valid are held unchanged; o_valid only falls after a
    // handshake. The input side has no ready: a beat offered while full
    // is dropped and flagged.
    // ------------------------------------------------------------------

    // Three AW+1 bit pointers:
    //   wr_ptr    : next RAM slot to write
    //   fetch_ptr : next RAM slot to load into the read register
    //   rd_ptr    : oldest beat not yet handed off
    // The beat in the output register keeps its RAM slot until it is
    // handed off, so wr_ptr - rd_ptr counts RAM plus output register and
    // full is the classic pointer test on wr_ptr/rd_ptr.
    logic [AW:0] wr_ptr_q,    wr_ptr_d;
    logic [AW:0] fetch_ptr_q, fetch_ptr_d;
    logic [AW:0] rd_ptr_q,    rd_ptr_d;
    logic        o_valid_q,   o_valid_d;
    logic        frame_done_q;

    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          out_hs;
    logic [BW-1:0] ram_wdata;
    logic [BW-1:0] ram_rdata;
    logic [BW-1:0] out_beat;

    // Full uses registered pointers only: a read in the same cycle does
    // not make room for the incoming beat.
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en  = i_valid && !full;
    assign out_hs = o_valid_q && o_ready;

    // Prefetch into the read register whenever something unread sits in
    // RAM and the output register is empty or being emptied this cycle.
    // This gives 1-cycle write-to-output latency and back-to-back output.
    assign rd_en  = (fetch_ptr_q != wr_ptr_q) && (!o_valid_q || o_ready);

    assign ram_wdata = {i_eop, i_sop, i_data};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        o_valid_d   = o_valid_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            fetch_ptr_d = fetch_ptr_q + PTR_ONE;
        end
        if (out_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            o_valid_d = 1'b1;
        end else if (out_hs) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            rd_ptr_q     <= '0;
            o_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            o_valid_q    <= o_valid_d;
            frame_done_q <= out_hs && out_beat[BW-1];
        end
    end

    sdp_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (rd_en),
        .raddr_i (fetch_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset, so the outputs are forced to
    // zero whenever no beat is presented.
    assign out_beat = o_valid_q ? ram_rdata : '0;

    assign o_valid     = o_valid_q;
    assign o_eop       = out_beat[BW-1];
    assign o_sop       = out_beat[BW-2];
    assign o_data      = out_beat[PIX_WIDTH-1:0];
    assign fill_level  = wr_ptr_q - rd_ptr_q;
    assign almost_full = (fill_level >= AF_LEVEL);
    assign frame_done  = frame_done_q;

    // ------------------------------------------------------------------
    // Frame checker. Acts only on accepted beats; dropped beats are
    // already covered by err_overflow.
    // ------------------------------------------------------------------
    chk_state_t    state_q,     state_d;
    logic [CW-1:0] pix_cnt_q,   pix_cnt_d;
    logic [CW-1:0] exp_total_q, exp_total_d;
    logic [CW-1:0] live_total;
    logic [CW-1:0] cnt_inc;
    logic          framing_evt;
    logic          length_evt;
    logic          overflow_evt;

    assign live_total = {{DIM_WIDTH{1'b0}}, exp_width} *
                        {{DIM_WIDTH{1'b0}}, exp_height};

    // Saturating increment so an endless frame cannot wrap back into a
    // count that happens to match.
    assign cnt_inc = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        exp_total_d = exp_total_q;
        framing_evt = 1'b0;
        length_evt  = 1'b0;
        if (wr_en) begin
            if (i_sop) begin
                // A sop always starts a fresh count with freshly sampled
                // dimensions; a sop inside a frame is also a framing error.
                framing_evt = (state_q == IN_FRAME);
                exp_total_d = live_total;
                pix_cnt_d   = CNT_ONE;
                if (i_eop) begin
                    length_evt = (live_total != CNT_ONE);
                    state_d    = IDLE;
                end else begin
                    state_d    = IN_FRAME;
                end
            end else if (state_q == IDLE) begin
                framing_evt = 1'b1;
            end else begin
                pix_cnt_d = cnt_inc;
                if (i_eop) begin
                    length_evt = (cnt_inc != exp_total_q);
                    state_d    = IDLE;
                end
            end
        end
    end

    assign overflow_evt = i_valid && full;

    logic err_overflow_q, err_framing_q, err_length_q;

    // clr_err clears at the next edge, but an error event in the same
    // cycle keeps its flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pix_cnt_q      <= '0;
            exp_total_q    <= '0;
            err_overflow_q <= 1'b0;
            err_framing_q  <= 1'b0;
            err_length_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            exp_total_q    <= exp_total_d;
            err_overflow_q <= (err_overflow_q && !clr_err) || overflow_evt;
            err_framing_q  <= (err_framing_q  && !clr_err) || framing_evt;
            err_length_q   <= (err_length_q   && !clr_err) || length_evt;
        end
    end

    assign err_overflow    = err_overflow_q;
    assign err_framing     = err_framing_q;
    assign err_length      = err_length_q;
    assign dbg_chk_state_o = state_q;

endmodule : conv_out_buffer

// File: tb/tb_conv_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv_out_buffer
//
// Drives pixel frames into conv_out_buffer (DEPTH=16) and checks the output
// stream against an expected-beat queue, plus fill level, almost_full,
// frame_done and the sticky error flags at chosen points.
// -----------------------------------------------------------------------------
module tb_conv_out_buffer;
    import conv_stream_pkg::*;

    localparam int PW    = 8;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = PW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [PW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_sop = 1'b0;
    logic          i_eop = 1'b0;
    logic [PW-1:0] o_data;
    logic          o_valid, o_sop, o_eop;
    logic          o_ready = 1'b0;
    logic [DW-1:0] exp_width = '0;
    logic [DW-1:0] exp_height = '0;
    logic          clr_err = 1'b0;
    logic [AW:0]   fill_level;
    logic          almost_full, frame_done;
    logic          err_overflow, err_framing, err_length;
    chk_state_t    dbg_state;

    conv_out_buffer #(
        .PIX_WIDTH (PW),
        .DEPTH     (DEPTH),
        .DIM_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .i_sop           (i_sop),
        .i_eop           (i_eop),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_sop           (o_sop),
        .o_eop           (o_eop),
        .o_ready         (o_ready),
        .exp_width       (exp_width),
        .exp_height      (exp_height),
        .clr_err         (clr_err),
        .fill_level      (fill_level),
        .almost_full     (almost_full),
        .frame_done      (frame_done),
        .err_overflow    (err_overflow),
        .err_framing     (err_framing),
        .err_length      (err_length),
        .dbg_chk_state_o (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag, input logic ovf, input logic frm, input logic len);
        check({tag, "_err_overflow"}, err_overflow, ovf);
        check({tag, "_err_framing"},  err_framing,  frm);
        check({tag, "_err_length"},   err_length,   len);
    endtask

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int            mdl_fill = 0;
    logic          done_exp = 1'b0;
    int            done_cnt = 0;
    logic          hs, acc;
    logic [BW-1:0] head;

    // Sampled mid-cycle: inputs and outputs here are what the next rising
    // edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            check("fill_level", fill_level, mdl_fill);
            check("almost_full", almost_full, mdl_fill >= DEPTH - 4);
            check("frame_done", frame_done, done_exp);
            if (frame_done) done_cnt++;
            hs = o_valid && o_ready;
            head = '0;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("o_valid_with_nothing_queued", o_valid, 1'b0);
                end else begin
                    head = exp_q[0];
                    check("o_data", o_data, head[PW-1:0]);
                    check("o_sop",  o_sop,  head[PW]);
                    check("o_eop",  o_eop,  head[PW+1]);
                end
            end
            done_exp = hs && head[PW+1];
            if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
            acc = i_valid && (mdl_fill < DEPTH);
            if (acc) exp_q.push_back({i_eop, i_sop, i_data});
            mdl_fill = mdl_fill + int'(acc) - int'(hs);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [PW-1:0] d, input logic s, input logic e);
        i_data  = d;
        i_sop   = s;
        i_eop   = e;
        i_valid = 1'b1;
        tick(1);
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        i_data  = '0;
    endtask

    task automatic send_frame(input int n, input logic first_sop, input logic rand_ready);
        for (int k = 0; k < n; k++) begin
            if (rand_ready) o_ready = 1'($urandom_range(0, 1));
            drive_beat(PW'($urandom_range(0, 255)), first_sop && (k == 0), k == n - 1);
        end
    endtask

    task automatic set_exp(input int w, input int h);
        exp_width  = DW'(w);
        exp_height = DW'(h);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        o_ready = 1'b1;
        while (exp_q.size() != 0 && c < max_cycles) begin
            tick(1);
            c++;
        end
        check("drain_in_time", exp_q.size() == 0, 1'b1);
        tick(2);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        mdl_fill = 0;
        done_exp = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int done_before;

    initial begin
        apply_reset();
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_data", o_data, '0);
        check("rst_o_sop", o_sop, 1'b0);
        check("rst_o_eop", o_eop, 1'b0);
        check("rst_fill", fill_level, '0);
        check("rst_state", dbg_state, IDLE);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // 1: 4x3 frame, consumer always ready
        set_exp(4, 3);
        o_ready  = 1'b1;
        done_cnt = 0;
        drive_beat(8'h11, 1'b1, 1'b0);
        check("t1_no_output_yet", o_valid, 1'b0);
        for (int k = 1; k < 12; k++) begin
            drive_beat(PW'(8'h11 + k), 1'b0, k == 11);
            if (k == 1) check("t1_latency_one", o_valid, 1'b1);
        end
        wait_drain(40);
        check("t1_frame_done_count", done_cnt, 1);
        check_flags("t1", 1'b0, 1'b0, 1'b0);

        // 2: same frame fully stalled, then drained back-to-back
        o_ready = 1'b0;
        send_frame(12, 1'b1, 1'b0);
        tick(3);
        check("t2_fill_peak", fill_level, 12);
        check("t2_almost_full", almost_full, 1'b1);
        check("t2_held_valid", o_valid, 1'b1);
        check("t2_held_sop", o_sop, 1'b1);
        o_ready = 1'b1;
        tick(12);
        check("t2_no_bubbles_fill", fill_level, 0);
        tick(2);
        check_flags("t2", 1'b0, 1'b0, 1'b0);

        // 3: overflow with the buffer stalled
        o_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_beat(PW'(k + 1), k == 0, 1'b0);
            if (k == 15) check("t3_no_ovf_at_16", err_overflow, 1'b0);
            if (k == 16) check("t3_ovf_at_17", err_overflow, 1'b1);
        end
        check("t3_fill_full", fill_level, DEPTH);
        check("t3_almost_full", almost_full, 1'b1);
        wait_drain(40);
        pulse_clr();
        check("t3_ovf_cleared", err_overflow, 1'b0);
        drive_beat(8'hEE, 1'b0, 1'b1);      // closes the 16-beat frame
        check("t3_len_after_close", err_length, 1'b1);
        check("t3_framing_clean", err_framing, 1'b0);
        pulse_clr();
        check_flags("t3_cleared", 1'b0, 1'b0, 1'b0);
        // clear and error in the same cycle: error wins
        clr_err = 1'b1;
        drive_beat(8'h5A, 1'b0, 1'b0);
        clr_err = 1'b0;
        check("t3_clr_vs_event", err_framing, 1'b1);
        pulse_clr();
        check("t3_clr_again", err_framing, 1'b0);
        wait_drain(20);

        // 4: short frame, then a good one; err_length stays sticky
        set_exp(4, 3);
        send_frame(11, 1'b1, 1'b0);
        wait_drain(40);
        check("t4_short_len", err_length, 1'b1);
        send_frame(12, 1'b1, 1'b0);
        wait_drain(40);
        check("t4_len_sticky", err_length, 1'b1);
        check("t4_framing", err_framing, 1'b0);
        pulse_clr();

        // 5: framing cases
        drive_beat(8'h33, 1'b0, 1'b0);
        check("t5_no_sop_framing", err_framing, 1'b1);
        check("t5_no_sop_len", err_length, 1'b0);
        pulse_clr();
        drive_beat(8'h40, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive_beat(PW'(8'h41 + k), 1'b0, 1'b0);
        check("t5_in_frame", dbg_state, IN_FRAME);
        send_frame(12, 1'b1, 1'b0);          // restarts the count at its sop
        check("t5_mid_sop_framing", err_framing, 1'b1);
        check("t5_restart_len_ok", err_length, 1'b0);
        check("t5_back_idle", dbg_state, IDLE);
        wait_drain(40);
        pulse_clr();
        set_exp(1, 1);
        drive_beat(8'h77, 1'b1, 1'b1);
        check_flags("t5_one_pixel", 1'b0, 1'b0, 1'b0);
        set_exp(2, 1);
        drive_beat(8'h78, 1'b1, 1'b1);
        check("t5_one_pixel_vs_2", err_length, 1'b1);
        wait_drain(20);
        pulse_clr();
        // dimensions are sampled on sop only
        set_exp(4, 3);
        drive_beat(8'h90, 1'b1, 1'b0);
        set_exp(5, 5);
        for (int k = 1; k < 12; k++) drive_beat(PW'(8'h90 + k), 1'b0, k == 11);
        check_flags("t5_exp_sampled", 1'b0, 1'b0, 1'b0);
        wait_drain(40);

        // 6: reset mid-frame with beats buffered and a flag set
        drive_beat(8'h01, 1'b0, 1'b0);
        wait_drain(20);
        check("t6_pre_flag", err_framing, 1'b1);
        set_exp(4, 3);
        o_ready = 1'b0;
        drive_beat(8'hA0, 1'b1, 1'b0);
        for (int k = 1; k < 6; k++) drive_beat(PW'(8'hA0 + k), 1'b0, 1'b0);
        check("t6_buffered", fill_level, 6);
        apply_reset();
        #1;
        check("t6_rst_o_valid", o_valid, 1'b0);
        check("t6_rst_fill", fill_level, 0);
        check("t6_rst_o_data", o_data, '0);
        check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        o_ready = 1'b1;
        drive_beat(8'hA6, 1'b0, 1'b0);
        drive_beat(8'hA7, 1'b0, 1'b1);
        check("t6_tail_framing", err_framing, 1'b1);
        wait_drain(20);
        pulse_clr();
        done_before = done_cnt;
        send_frame(12, 1'b1, 1'b0);
        wait_drain(40);
        check_flags("t6_clean_frame", 1'b0, 1'b0, 1'b0);
        check("t6_frame_done", done_cnt - done_before, 1);

        // 7: random consumer stalls
        done_before = done_cnt;
        send_frame(12, 1'b1, 1'b1);
        wait_drain(60);
        check_flags("t7", 1'b0, 1'b0, 1'b0);
        check("t7_frame_done", done_cnt - done_before, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_conv_out_buffer
